// File: rtl/ct_lpmd_define.sv
// Shared definitions for the low-power-mode sequencer: state encodings and counter widths.
package ct_lpmd_define;

  typedef enum logic [2:0] {
    ST_RUN     = 3'd0,
    ST_DRAIN   = 3'd1,
    ST_HANDSHK = 3'd2,
    ST_SLEEP   = 3'd3,
    ST_WAKE    = 3'd4
  } lpmd_state_e;

  localparam int WAKE_CNT_W = 4;
  localparam int TMO_CNT_W  = 8;

endpackage

// File: rtl/ct_lpmd_wake_cnt.sv
// Loadable 4-bit down-counter timing the post-wakeup settle interval.
// zero reports the value the counter holds after the current edge, so the FSM can leave WAKE on time.
module ct_lpmd_wake_cnt
  import ct_lpmd_define::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic [WAKE_CNT_W-1:0] load_val,
  input  logic                  dec,
  output logic                  zero
);

  logic [WAKE_CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - WAKE_CNT_W'(1);
    end
  end

  always_comb begin
    zero = 1'b0;
    if (load) begin
      zero = (load_val == '0);
    end else if (dec) begin
      zero = (cnt <= WAKE_CNT_W'(1));
    end else begin
      zero = (cnt == '0);
    end
  end

endmodule

// File: rtl/ct_lpmd_sleep_ctrl.sv
// WFI low-power sequencer: drain, SoC sleep handshake, clock gating and wakeup settle.
// Optional drain timeout is enabled by defining CT_LPMD_DRAIN_TIMEOUT_EN.
module ct_lpmd_sleep_ctrl
  import ct_lpmd_define::*;
#(
  parameter int WAKE_CYCLES   = 4,
  parameter int DRAIN_TIMEOUT = 255
) (
  input  logic       forever_cpuclk,
  input  logic       cpurst_b,
  input  logic       cp0_lpmd_wfi_req,
  input  logic       rtu_lpmd_pipe_empty,
  input  logic       lsu_lpmd_no_op,
  input  logic       ifu_lpmd_no_op,
  input  logic       pad_lpmd_int_pending,
  input  logic       had_lpmd_dbg_req,
  input  logic       ext_lpmd_ack,
  output logic       lpmd_ext_req,
  output logic       lpmd_xx_normal_work,
  output logic       lpmd_xx_int_wakeup,
  output logic       lpmd_xx_dbg_wakeup,
  output logic       lpmd_cp0_wfi_done,
  output logic       lpmd_cp0_drain_abort,
  output logic [2:0] lpmd_top_cur_state
);

  localparam logic [WAKE_CNT_W-1:0] WAKE_VAL = WAKE_CNT_W'(WAKE_CYCLES);

  if (WAKE_CYCLES < 1 || WAKE_CYCLES > 15 || DRAIN_TIMEOUT < 1 || DRAIN_TIMEOUT > 255) begin : g_bad_param
    $error("ct_lpmd_sleep_ctrl: WAKE_CYCLES or DRAIN_TIMEOUT out of range");
  end

  lpmd_state_e state_reg, state_next;
  logic        pend_reg, pend_next;
  logic        int_wk_reg, int_wk_next;
  logic        dbg_wk_reg, dbg_wk_next;
  logic        done_reg, done_next;
  logic        wake_load, wake_dec, wake_zero;
  logic        wake_ev, idle_all, tmo_fire;

  assign wake_ev  = pad_lpmd_int_pending | had_lpmd_dbg_req;
  assign idle_all = rtu_lpmd_pipe_empty & lsu_lpmd_no_op & ifu_lpmd_no_op;

`ifdef CT_LPMD_DRAIN_TIMEOUT_EN
  localparam logic [TMO_CNT_W-1:0] TMO_LAST = TMO_CNT_W'(DRAIN_TIMEOUT - 1);

  logic [TMO_CNT_W-1:0] tmo_cnt;
  logic                 abort_reg;

  // Counter sits at zero outside DRAIN, so it is already clear on DRAIN entry.
  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      tmo_cnt   <= '0;
      abort_reg <= 1'b0;
    end else begin
      tmo_cnt   <= (state_reg == ST_DRAIN) ? tmo_cnt + TMO_CNT_W'(1) : '0;
      abort_reg <= tmo_fire;
    end
  end

  assign tmo_fire = (state_reg == ST_DRAIN) && (tmo_cnt == TMO_LAST) && !wake_ev && !idle_all;
  assign lpmd_cp0_drain_abort = abort_reg;
`else
  assign tmo_fire = 1'b0;
  assign lpmd_cp0_drain_abort = 1'b0;
`endif

  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      state_reg  <= ST_RUN;
      pend_reg   <= 1'b0;
      int_wk_reg <= 1'b0;
      dbg_wk_reg <= 1'b0;
      done_reg   <= 1'b0;
    end else begin
      state_reg  <= state_next;
      pend_reg   <= pend_next;
      int_wk_reg <= int_wk_next;
      dbg_wk_reg <= dbg_wk_next;
      done_reg   <= done_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    pend_next   = pend_reg;
    int_wk_next = 1'b0;
    dbg_wk_next = 1'b0;
    done_next   = 1'b0;
    wake_load   = 1'b0;
    wake_dec    = 1'b0;
    case (state_reg)
      ST_RUN: begin
        if (cp0_lpmd_wfi_req) begin
          if (wake_ev) begin
            done_next = 1'b1;
          end else begin
            state_next = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        if (wake_ev || tmo_fire) begin
          state_next = ST_WAKE;
          wake_load  = 1'b1;
        end else if (idle_all) begin
          state_next = ST_HANDSHK;
        end
      end
      ST_HANDSHK: begin
        if (wake_ev) begin
          pend_next = 1'b1;
        end
        // An event arriving together with the ack still cancels the sleep.
        if (ext_lpmd_ack) begin
          wake_load  = pend_reg | wake_ev;
          state_next = (pend_reg | wake_ev) ? ST_WAKE : ST_SLEEP;
        end
      end
      ST_SLEEP: begin
        if (wake_ev) begin
          state_next  = ST_WAKE;
          wake_load   = 1'b1;
          int_wk_next = pad_lpmd_int_pending;
          dbg_wk_next = had_lpmd_dbg_req;
        end
      end
      ST_WAKE: begin
        wake_dec = !ext_lpmd_ack;
        if (wake_zero) begin
          state_next = ST_RUN;
          done_next  = 1'b1;
          pend_next  = 1'b0;
        end
      end
      default: begin
        state_next = ST_RUN;
        pend_next  = 1'b0;
      end
    endcase
  end

  ct_lpmd_wake_cnt u_wake_cnt (
    .clk      (forever_cpuclk),
    .rst_n    (cpurst_b),
    .load     (wake_load),
    .load_val (WAKE_VAL),
    .dec      (wake_dec),
    .zero     (wake_zero)
  );

  assign lpmd_ext_req        = (state_reg == ST_HANDSHK) || (state_reg == ST_SLEEP);
  assign lpmd_xx_normal_work = (state_reg != ST_SLEEP);
  assign lpmd_xx_int_wakeup  = int_wk_reg;
  assign lpmd_xx_dbg_wakeup  = dbg_wk_reg;
  assign lpmd_cp0_wfi_done   = done_reg;
  assign lpmd_top_cur_state  = state_reg;

endmodule

// File: tb/tb_ct_lpmd_sleep_ctrl.sv
// Directed bench for ct_lpmd_sleep_ctrl; pulse outputs are matched against a scoreboard of expected events.
module tb_ct_lpmd_sleep_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       wfi_req = 1'b0;
  logic       pipe_empty = 1'b1;
  logic       lsu_no_op = 1'b1;
  logic       ifu_no_op = 1'b1;
  logic       int_pend = 1'b0;
  logic       dbg_req = 1'b0;
  logic       ext_ack = 1'b0;
  logic       ext_req, normal_work, int_wakeup, dbg_wakeup, wfi_done, drain_abort;
  logic [2:0] cur_state;

  localparam int K_INT = 0, K_DBG = 1, K_DONE = 2, K_ABORT = 3;

  typedef struct {
    int kind;
    int cyc;
  } ev_t;

  ev_t sb[$];
  int  cyc = 0;
  int  n_cmp = 0;
  int  n_err = 0;
  int  b;

  ct_lpmd_sleep_ctrl #(.WAKE_CYCLES(4), .DRAIN_TIMEOUT(8)) dut (
    .forever_cpuclk       (clk),
    .cpurst_b             (rst_n),
    .cp0_lpmd_wfi_req     (wfi_req),
    .rtu_lpmd_pipe_empty  (pipe_empty),
    .lsu_lpmd_no_op       (lsu_no_op),
    .ifu_lpmd_no_op       (ifu_no_op),
    .pad_lpmd_int_pending (int_pend),
    .had_lpmd_dbg_req     (dbg_req),
    .ext_lpmd_ack         (ext_ack),
    .lpmd_ext_req         (ext_req),
    .lpmd_xx_normal_work  (normal_work),
    .lpmd_xx_int_wakeup   (int_wakeup),
    .lpmd_xx_dbg_wakeup   (dbg_wakeup),
    .lpmd_cp0_wfi_done    (wfi_done),
    .lpmd_cp0_drain_abort (drain_abort),
    .lpmd_top_cur_state   (cur_state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic expect_ev(input int kind, input int at);
    ev_t e;
    e.kind = kind;
    e.cyc  = at;
    sb.push_back(e);
  endtask

  task automatic check_pulse(input int kind, input string tag, input logic val);
    int idx = -1;
    for (int i = 0; i < sb.size(); i++) begin
      if (idx < 0 && sb[i].kind == kind && sb[i].cyc == cyc) idx = i;
    end
    if (idx >= 0) sb.delete(idx);
    chk(tag, 32'(val), (idx >= 0) ? 32'd1 : 32'd0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    check_pulse(K_INT,   "int_wakeup",  int_wakeup);
    check_pulse(K_DBG,   "dbg_wakeup",  dbg_wakeup);
    check_pulse(K_DONE,  "wfi_done",    wfi_done);
    check_pulse(K_ABORT, "drain_abort", drain_abort);
  endtask

  task automatic wait_to(input int n);
    while (cyc < n) tick();
  endtask

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_state", 32'(cur_state), 32'd0);
    chk("rst_normal_work", 32'(normal_work), 32'd1);
    chk("rst_ext_req", 32'(ext_req), 32'd0);
    chk("rst_pulses", 32'({int_wakeup, dbg_wakeup, wfi_done, drain_abort}), 32'd0);
    rst_n = 1'b1;
    cyc = 0;

    // 1: idle core, full sleep and interrupt wakeup
    wait_to(2);
    wfi_req = 1'b1;
    tick();
    wfi_req = 1'b0;
    chk("t1_drain_state", 32'(cur_state), 32'd1);
    chk("t1_drain_ext_req", 32'(ext_req), 32'd0);
    tick();
    chk("t1_hs_state", 32'(cur_state), 32'd2);
    chk("t1_hs_ext_req", 32'(ext_req), 32'd1);
    wait_to(6);
    ext_ack = 1'b1;
    tick();
    chk("t1_sleep_state", 32'(cur_state), 32'd3);
    chk("t1_sleep_normal_work", 32'(normal_work), 32'd0);
    while (cyc < 20) begin
      tick();
      chk("t1_sleep_ext_req", 32'(ext_req), 32'd1);
      chk("t1_sleep_nw", 32'(normal_work), 32'd0);
    end
    int_pend = 1'b1;
    expect_ev(K_INT, 21);
    expect_ev(K_DONE, 25);
    tick();
    int_pend = 1'b0;
    ext_ack = 1'b0;
    chk("t1_wake_state", 32'(cur_state), 32'd4);
    chk("t1_wake_normal_work", 32'(normal_work), 32'd1);
    chk("t1_wake_ext_req", 32'(ext_req), 32'd0);
    wait_to(24);
    chk("t1_wake_hold", 32'(cur_state), 32'd4);
    tick();
    chk("t1_run_state", 32'(cur_state), 32'd0);

    // 2: WFI with debug request pending retires immediately
    wait_to(cyc + 2);
    b = cyc;
    dbg_req = 1'b1;
    wfi_req = 1'b1;
    expect_ev(K_DONE, b + 1);
    tick();
    wfi_req = 1'b0;
    chk("t2_state", 32'(cur_state), 32'd0);
    chk("t2_ext_req", 32'(ext_req), 32'd0);
    tick();
    dbg_req = 1'b0;
    chk("t2_state2", 32'(cur_state), 32'd0);

    // 3: interrupt while draining aborts the sleep
    wait_to(cyc + 2);
    b = cyc;
    lsu_no_op = 1'b0;
    wfi_req = 1'b1;
    tick();
    wfi_req = 1'b0;
    chk("t3_drain_state", 32'(cur_state), 32'd1);
    int_pend = 1'b1;
    expect_ev(K_DONE, b + 6);
    tick();
    int_pend = 1'b0;
    lsu_no_op = 1'b1;
    chk("t3_wake_state", 32'(cur_state), 32'd4);
    chk("t3_ext_req", 32'(ext_req), 32'd0);
    wait_to(b + 5);
    chk("t3_ext_req_late", 32'(ext_req), 32'd0);
    tick();
    chk("t3_run_state", 32'(cur_state), 32'd0);

    // 4a: interrupt and debug together in SLEEP
    wait_to(cyc + 2);
    b = cyc;
    wfi_req = 1'b1;
    tick();
    wfi_req = 1'b0;
    tick();
    ext_ack = 1'b1;
    tick();
    ext_ack = 1'b0;
    chk("t4a_sleep_state", 32'(cur_state), 32'd3);
    wait_to(b + 5);
    int_pend = 1'b1;
    dbg_req = 1'b1;
    expect_ev(K_INT, b + 6);
    expect_ev(K_DBG, b + 6);
    expect_ev(K_DONE, b + 10);
    tick();
    int_pend = 1'b0;
    dbg_req = 1'b0;
    chk("t4a_wake_state", 32'(cur_state), 32'd4);
    wait_to(b + 10);
    chk("t4a_run_state", 32'(cur_state), 32'd0);

    // 4b: interrupt during handshake; ack held into WAKE stalls the settle count
    wait_to(cyc + 2);
    b = cyc;
    wfi_req = 1'b1;
    tick();
    wfi_req = 1'b0;
    tick();
    chk("t4b_hs_state", 32'(cur_state), 32'd2);
    int_pend = 1'b1;
    tick();
    int_pend = 1'b0;
    chk("t4b_hs_hold", 32'(cur_state), 32'd2);
    chk("t4b_nw_hs", 32'(normal_work), 32'd1);
    tick();
    ext_ack = 1'b1;
    expect_ev(K_DONE, b + 10);
    tick();
    chk("t4b_wake_state", 32'(cur_state), 32'd4);
    chk("t4b_nw_wake", 32'(normal_work), 32'd1);
    tick();
    ext_ack = 1'b0;
    wait_to(b + 9);
    chk("t4b_wake_hold", 32'(cur_state), 32'd4);
    tick();
    chk("t4b_run_state", 32'(cur_state), 32'd0);

    // 5: pipeline never drains
    wait_to(cyc + 2);
    b = cyc;
    pipe_empty = 1'b0;
    wfi_req = 1'b1;
    tick();
    wfi_req = 1'b0;
`ifdef CT_LPMD_DRAIN_TIMEOUT_EN
    expect_ev(K_ABORT, b + 9);
    expect_ev(K_DONE, b + 13);
    wait_to(b + 8);
    chk("t5_drain_hold", 32'(cur_state), 32'd1);
    tick();
    pipe_empty = 1'b1;
    chk("t5_wake_state", 32'(cur_state), 32'd4);
    wait_to(b + 13);
    chk("t5_run_state", 32'(cur_state), 32'd0);
`else
    wait_to(b + 12);
    chk("t5_drain_hold", 32'(cur_state), 32'd1);
    int_pend = 1'b1;
    expect_ev(K_DONE, b + 17);
    tick();
    int_pend = 1'b0;
    pipe_empty = 1'b1;
    chk("t5_wake_state", 32'(cur_state), 32'd4);
    wait_to(b + 17);
    chk("t5_run_state", 32'(cur_state), 32'd0);
`endif

    // 6: reset during SLEEP, then a fresh sleep/debug-wake cycle
    wait_to(cyc + 2);
    b = cyc;
    wfi_req = 1'b1;
    tick();
    wfi_req = 1'b0;
    tick();
    ext_ack = 1'b1;
    tick();
    ext_ack = 1'b0;
    chk("t6_sleep_state", 32'(cur_state), 32'd3);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_state", 32'(cur_state), 32'd0);
    chk("t6_rst_normal_work", 32'(normal_work), 32'd1);
    chk("t6_rst_ext_req", 32'(ext_req), 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    b = cyc;
    wfi_req = 1'b1;
    tick();
    wfi_req = 1'b0;
    chk("t6_drain_state", 32'(cur_state), 32'd1);
    tick();
    ext_ack = 1'b1;
    tick();
    ext_ack = 1'b0;
    chk("t6_sleep_again", 32'(cur_state), 32'd3);
    dbg_req = 1'b1;
    expect_ev(K_DBG, b + 4);
    expect_ev(K_DONE, b + 8);
    tick();
    dbg_req = 1'b0;
    chk("t6_wake_state", 32'(cur_state), 32'd4);
    wait_to(b + 8);
    chk("t6_run_state", 32'(cur_state), 32'd0);

    wait_to(cyc + 3);
    chk("sb_leftover", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ct_lpmd_sleep_ctrl.md
# ct_lpmd_sleep_ctrl

Low-power-mode sequencer that produces the core clock-enable terms the core clock gate consumes. On a WFI request it drains the pipeline, performs a four-phase sleep handshake with the SoC, drops `lpmd_xx_normal_work` to gate `coreclk`, and on interrupt or debug wakeup restores the clock, waits a programmable settle time, then retires the WFI. It runs on the ungated clock so it can wake the core.

## Interface
Parameters:
- `WAKE_CYCLES`, default 4: settle cycles after wakeup before WFI retires; range 1..15, held in a 4-bit counter.
- `DRAIN_TIMEOUT`, default 255: drain abort limit; range 1..255, 8-bit. Used only with the timeout macro.

Ports:
- `forever_cpuclk` in 1: ungated core clock.
- `cpurst_b` in 1: reset, asynchronous, active-low.
- `cp0_lpmd_wfi_req` in 1: one-cycle WFI request, sampled only in RUN.
- `rtu_lpmd_pipe_empty` in 1: retire pipeline empty.
- `lsu_lpmd_no_op` in 1: LSU idle.
- `ifu_lpmd_no_op` in 1: IFU idle.
- `pad_lpmd_int_pending` in 1: interrupt pending, level.
- `had_lpmd_dbg_req` in 1: debug request, level.
- `ext_lpmd_ack` in 1: SoC sleep acknowledge.
- `lpmd_ext_req` out 1: sleep request to SoC.
- `lpmd_xx_normal_work` out 1: clock-enable term; low only while sleeping.
- `lpmd_xx_int_wakeup` out 1: one-cycle pulse, interrupt wakeup.
- `lpmd_xx_dbg_wakeup` out 1: one-cycle pulse, debug wakeup.
- `lpmd_cp0_wfi_done` out 1: one-cycle pulse, WFI retired.
- `lpmd_cp0_drain_abort` out 1: one-cycle pulse, drain timed out.
- `lpmd_top_cur_state` out 3: state register, for debug.

## Operation
State encoding: RUN=0, DRAIN=1, HANDSHK=2, SLEEP=3, WAKE=4.
- RUN:
  - `wfi_req` with no int and no dbg: go to DRAIN.
  - `wfi_req` with int or dbg high: stay in RUN and pulse `wfi_done` on the next cycle.
- DRAIN:
  - int or dbg high: go to WAKE. This aborts the sleep; no `ext_req` is raised and no wakeup pulse is given.
  - All three idle inputs high in the same cycle: go to HANDSHK.
- HANDSHK:
  - `ext_req` stays high until `ext_ack` is high.
  - Any int/dbg seen in HANDSHK sets a sticky pending bit.
  - On ack: go to WAKE if the pending bit is set, otherwise go to SLEEP.
- SLEEP:
  - `normal_work`=0 and `ext_req`=1.
  - int or dbg high: go to WAKE and pulse the matching wakeup output(s). Both pulse if both inputs are high.
- WAKE:
  - `normal_work`=1 and `ext_req`=0.
  - The counter loads `WAKE_CYCLES` on entry and decrements only in cycles where `ext_ack` is low.
  - When the counter reaches 0: go to RUN and pulse `wfi_done`.
- Leaving WAKE clears the pending bit.
- `cp0_lpmd_wfi_req` outside RUN is ignored.
- Outputs are registers, or pure decodes of the state register.
- Reset values: state RUN, `normal_work`=1, all other outputs 0, counters 0, pending bit 0.

## Timing
- `wfi_req` in cycle N → state DRAIN in N+1.
- Idle inputs high in N+1 → HANDSHK and `ext_req`=1 in N+2.
- `ext_ack` high in cycle M → SLEEP and `normal_work`=0 in M+1.
- Wake event in cycle K → WAKE in K+1, with `normal_work`=1 and the wakeup pulse both in K+1.
- With `ext_ack` low from K+1 onward: RUN and `wfi_done` pulse in K+1+`WAKE_CYCLES`.
- A wake event in the same cycle as the idle inputs goes high (DRAIN) takes priority: go to WAKE.
- `ext_ack` is ignored outside HANDSHK and WAKE.
- Asserting `cpurst_b` at any time forces RUN immediately (`ext_req`=0, `normal_work`=1) without waiting for the SoC handshake.

## Configuration
- `CT_LPMD_DRAIN_TIMEOUT_EN` defined:
  - An 8-bit counter clears on DRAIN entry and increments each cycle in DRAIN.
  - At count `DRAIN_TIMEOUT` while DRAIN is not yet exited: go to WAKE and pulse `lpmd_cp0_drain_abort` in the same cycle the WAKE state is entered.
- Undefined: the counter is absent, `lpmd_cp0_drain_abort` is tied 0, and DRAIN waits indefinitely.

## Structure
- Shared define file `ct_lpmd_define` holds:
  - the state encodings;
  - the counter widths (4 and 8).
- Sub-module `ct_lpmd_wake_cnt`: loadable 4-bit down-counter with load, decrement-enable and zero flag. It sits inside WAKE.
- FSM, pending bit and timeout counter stay in the top module.

## Test plan
- Idle core, `WAKE_CYCLES`=4:
  - stimulus: `wfi_req` at cycle 2, ack at 6, int at 20, ack dropped at 21;
  - response: `ext_req` high 4..20, `normal_work` low 7..20, `int_wakeup` pulse at 21, `wfi_done` pulse at 25.
- `wfi_req` with `had_lpmd_dbg_req`=1 → state stays RUN, `wfi_done` at N+1, `ext_req` never high.
- Interrupt while in DRAIN (`lsu_no_op`=0) → WAKE the next cycle, `ext_req` never high, `wfi_done` after `WAKE_CYCLES`.
- int and dbg together in SLEEP → both wakeup pulses in the same cycle; int raised during HANDSHK → on ack go straight to WAKE, `normal_work` never drops.
- With `CT_LPMD_DRAIN_TIMEOUT_EN`, `DRAIN_TIMEOUT`=8, `rtu_pipe_empty`=0 → `drain_abort` pulse 8 cycles after DRAIN entry, then normal WAKE exit.
- `cpurst_b` low during SLEEP → `normal_work`=1, `ext_req`=0 and state 0 asynchronously; after release, a fresh `wfi_req` works normally.
